// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel edge engine: output mode,
// gradient width and the two output-shaping functions.
package sobel_pkg;

  typedef enum logic {
    SOBEL_MODE_MAG = 1'b0,  // clamped gradient magnitude
    SOBEL_MODE_BIN = 1'b1   // binary edge map against a threshold
  } sobel_mode_e;

  // Signed Gx/Gy and the unsigned L1 magnitude all fit in DW+3 bits.
  function automatic int unsigned sobel_grad_w(input int unsigned dw);
    return dw + 3;
  endfunction

  // Saturate a magnitude to the largest DW-bit value.
  function automatic logic [31:0] sobel_clamp(input logic [31:0] mag, input int unsigned dw);
    logic [31:0] max_v;
    max_v = (32'd1 << dw) - 32'd1;
    return (mag > max_v) ? max_v : mag;
  endfunction

  // Edge decision: at or above the threshold counts as an edge.
  function automatic logic sobel_thresh(input logic [31:0] mag, input logic [31:0] thr);
    return (mag >= thr);
  endfunction

endpackage

// File: rtl/sobel_edge_engine_if.sv
// Pixel-in / edge-out stream bundle plus run-time configuration.
// The master side drives samples and config; the slave side is the engine.
interface sobel_edge_engine_if #(
  parameter int DW     = 8,
  parameter int CH_OUT = 3
);
  logic [DW-1:0]                           in_data;
  logic                                    in_sof;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [CH_OUT*DW-1:0]                    out_data;
  logic                                    out_last;
  logic                                    out_valid;
  logic                                    out_ready;
  logic                                    cfg_mode;
  logic [sobel_pkg::sobel_grad_w(DW)-1:0]  cfg_thresh;

  modport master (
    output in_data, in_sof, in_valid, out_ready, cfg_mode, cfg_thresh,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_sof, in_valid, out_ready, cfg_mode, cfg_thresh,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-line shift RAM: column x of both lines is read combinationally,
// and on a write the new sample enters line0 while line0's old word
// moves down into line1. Contents are never reset.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DW-1:0]            din_i,
  output logic [DW-1:0]            line0_o,
  output logic [DW-1:0]            line1_o
);
  logic [DW-1:0] line0_mem [DEPTH];
  logic [DW-1:0] line1_mem [DEPTH];

  assign line0_o = line0_mem[addr_i];
  assign line1_o = line1_mem[addr_i];

  // Push the new sample into line0 and age the previous line0 word into line1.
  always_ff @(posedge clk) begin
    if (we_i) begin
      line0_mem[addr_i] <= din_i;
      line1_mem[addr_i] <= line0_mem[addr_i];
    end
  end
endmodule

// File: rtl/sobel_edge_engine.sv
// Streaming 3x3 Sobel edge engine with ready/valid backpressure.
// Pipeline: window -> Gx/Gy -> shaped output; one global enable stalls all.
module sobel_edge_engine
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DW     = 8,
  parameter int CH_OUT = 3
) (
  input logic               clk,
  input logic               rst_p,
  sobel_edge_engine_if.slave bus
);
  localparam int GW = sobel_grad_w(DW);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic en, acc, at_origin;
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic [DW-1:0] lb0, lb1;
  logic [DW-1:0] col_new [3];
  logic [DW-1:0] win_q [3][3];
  logic          win_valid_q, win_last_q;
  sobel_mode_e   win_mode_q, shadow_mode_q, cfg_mode_now, s1_mode_q;
  logic [GW-1:0] win_thr_q, shadow_thr_q, cfg_thr_now, s1_thr_q;
  logic signed [GW-1:0] a [3][3];
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic          s1_valid_q, s1_last_q;
  logic [GW-1:0] abs_x, abs_y, mag;
  logic [31:0]   clamp_w;
  logic [DW-1:0] res_d, res_q;
  logic          out_valid_q, out_last_q;

  // Everything advances only when the output register is free or draining.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign acc          = bus.in_valid && en;

  // A start-of-frame sample is placed at (0,0) whatever the counters say.
  assign cur_x     = bus.in_sof ? '0 : x_q;
  assign cur_y     = bus.in_sof ? '0 : y_q;
  assign at_origin = (cur_x == '0) && (cur_y == '0);

  // Config is sampled at the frame origin and otherwise comes from the shadow copy.
  assign cfg_mode_now = at_origin ? sobel_mode_e'(bus.cfg_mode) : shadow_mode_q;
  assign cfg_thr_now  = at_origin ? bus.cfg_thresh : shadow_thr_q;

  // Raster position of the next sample, wrapping at the end of line and frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (acc) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
        y_d = cur_y;
      end
    end
  end

  // Counter and shadow-config registers.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      x_q           <= '0;
      y_q           <= '0;
      shadow_mode_q <= SOBEL_MODE_MAG;
      shadow_thr_q  <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (acc && at_origin) begin
        shadow_mode_q <= cfg_mode_now;
        shadow_thr_q  <= cfg_thr_now;
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_line_buffer (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (cur_x),
    .din_i   (bus.in_data),
    .line0_o (lb0),
    .line1_o (lb1)
  );

  // New right-hand column, oldest line on top.
  assign col_new[0] = lb1;
  assign col_new[1] = lb0;
  assign col_new[2] = bus.in_data;

  // Window pixels shift left on every accepted sample.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
        win_q[r][2] <= col_new[r];
      end
    end
  end

  // Window tag: valid only for interior centres; config travels with the pixel.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_mode_q  <= SOBEL_MODE_MAG;
      win_thr_q   <= '0;
    end else if (en) begin
      win_valid_q <= acc && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
      win_last_q  <= acc && (cur_x == X_LAST) && (cur_y == Y_LAST);
      if (acc) begin
        win_mode_q <= cfg_mode_now;
        win_thr_q  <= cfg_thr_now;
      end
    end
  end

  // Sobel kernels on zero-extended window samples.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        a[r][c] = $signed(GW'(win_q[r][c]));
      end
    end
    gx_d = (a[0][2] + (a[1][2] <<< 1) + a[2][2]) - (a[0][0] + (a[1][0] <<< 1) + a[2][0]);
    gy_d = (a[2][0] + (a[2][1] <<< 1) + a[2][2]) - (a[0][0] + (a[0][1] <<< 1) + a[0][2]);
  end

  // Gradient stage registers.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      gx_q       <= '0;
      gy_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= SOBEL_MODE_MAG;
      s1_thr_q   <= '0;
    end else if (en) begin
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      s1_valid_q <= win_valid_q;
      s1_last_q  <= win_last_q;
      s1_mode_q  <= win_mode_q;
      s1_thr_q   <= win_thr_q;
    end
  end

  // L1 magnitude, then clamp or threshold depending on the frame's mode.
  always_comb begin
    abs_x   = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    abs_y   = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag     = abs_x + abs_y;
    clamp_w = sobel_clamp(32'(mag), DW);
    if (s1_mode_q == SOBEL_MODE_BIN) begin
      res_d = {DW{sobel_thresh(32'(mag), 32'(s1_thr_q))}};
    end else begin
      res_d = clamp_w[DW-1:0];
    end
  end

  // Output register; holds its value while downstream is not ready.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (en) begin
      res_q       <= res_d;
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q && s1_last_q;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

  for (genvar gi = 0; gi < CH_OUT; gi++) begin : g_chan
    assign bus.out_data[gi*DW +: DW] = res_q;
  end
endmodule

// File: tb/tb_sobel_edge_engine.sv
// Scoreboard bench for sobel_edge_engine on a 5x4 image.
module tb_sobel_edge_engine;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int CH = 3;

  logic clk = 1'b0;
  logic rst_p;
  always #5 clk = ~clk;

  sobel_edge_engine_if #(.DW(DW), .CH_OUT(CH)) bus ();

  sobel_edge_engine #(.IMG_W(W), .IMG_H(H), .DW(DW), .CH_OUT(CH)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  logic [CH*DW:0] exp_q[$];   // {last, data}
  logic [CH*DW:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    if (!rst_p && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%06h, required no output", bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] out data=0x%06h last=%0b (exp 0x%06h last=%0b)",
                 bus.out_data, bus.out_last, mon_e[CH*DW-1:0], mon_e[CH*DW]);
        check("out_data", 32'(bus.out_data), 32'(mon_e[CH*DW-1:0]));
        check("out_last", 32'(bus.out_last), 32'(mon_e[CH*DW]));
      end
    end
    if (bus.in_valid && bus.in_ready) acc_cnt++;
  end

  function automatic logic [7:0] pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 8'd100;
      1:       return (x >= 2) ? 8'd255 : 8'd0;
      2:       return 8'(10 * x);
      default: return 8'(37 * x + 53 * y + 11);
    endcase
  endfunction

  task automatic send_pixel(input logic [7:0] d, input logic sof);
    int k;
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", k);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int pat, input int n, input logic sof_first,
                            input int chg_at, input logic [10:0] chg_thr);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) bus.cfg_thresh = chg_thr;
      send_pixel(pix(pat, i % W, i / W), sof_first && (i == 0));
    end
  endtask

  // Six interior outputs: two rows of centres x=1..3, last flag on the final one.
  task automatic expect_frame(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2);
    logic [7:0] v;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        v = (c == 0) ? v0 : (c == 1) ? v1 : v2;
        exp_q.push_back({(r == 1 && c == 2), {CH{v}}});
      end
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    logic [23:0] snap_d;
    logic        snap_l;
    int          snap_acc;

    bus.in_valid   = 1'b0;
    bus.in_sof     = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.cfg_mode   = 1'b0;
    bus.cfg_thresh = '0;
    rst_p          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_p = 1'b0;
    @(posedge clk);
    #1;

    // Flat frame: no gradient anywhere.
    expect_frame(8'h00, 8'h00, 8'h00);
    send_frame(0, 20, 1'b1, -1, 11'd0);
    drain("flat");

    // Vertical edge between columns 1 and 2: Gx=1020 saturates.
    expect_frame(8'hFF, 8'hFF, 8'h00);
    send_frame(1, 20, 1'b1, -1, 11'd0);
    drain("vedge");

    // Ramp, binary mode, mag=80 >= 80; mid-frame change to 81 must not apply yet.
    bus.cfg_mode   = 1'b1;
    bus.cfg_thresh = 11'd80;
    expect_frame(8'hFF, 8'hFF, 8'hFF);
    send_frame(2, 20, 1'b1, 10, 11'd81);
    drain("ramp_t80");

    // Next frame picks up threshold 81: mag=80 is below it.
    expect_frame(8'h00, 8'h00, 8'h00);
    send_frame(2, 20, 1'b1, -1, 11'd0);
    drain("ramp_t81");

    // Backpressure: hold out_ready low for 10 cycles during the vertical-edge frame.
    bus.cfg_mode = 1'b0;
    expect_frame(8'hFF, 8'hFF, 8'h00);
    fork
      send_frame(1, 20, 1'b1, -1, 11'd0);
      begin
        k = 0;
        while (!bus.out_valid && k < 200) begin
          @(negedge clk);
          k++;
        end
        check("stall_first_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        snap_d   = bus.out_data;
        snap_l   = bus.out_last;
        snap_acc = acc_cnt;
        repeat (10) begin
          @(negedge clk);
          check("stall_in_ready",  32'(bus.in_ready),  32'd0);
          check("stall_out_valid", 32'(bus.out_valid), 32'd1);
          check("stall_out_data",  32'(bus.out_data),  32'(snap_d));
          check("stall_out_last",  32'(bus.out_last),  32'(snap_l));
        end
        check("stall_no_accept", 32'(acc_cnt), 32'(snap_acc));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stall");

    // Start-of-frame resync on the 8th pixel of a partial frame.
    send_frame(3, 7, 1'b1, -1, 11'd0);
    expect_frame(8'h50, 8'h50, 8'h50);
    send_frame(2, 20, 1'b1, -1, 11'd0);
    drain("sof");

    // Asynchronous reset with outputs in flight.
    exp_q.push_back({1'b0, 24'h505050});
    send_frame(2, 14, 1'b1, -1, 11'd0);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("prerst_out_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_p = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data",  32'(bus.out_data),  32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_p = 1'b0;
    check("arst_pending", 32'(exp_q.size()), 32'd0);
    expect_frame(8'h50, 8'h50, 8'h50);
    send_frame(2, 20, 1'b0, -1, 11'd0);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
